// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR register file with counters and trap state
//
// Purpose: holds the M-mode CSRs at the writeback end of the pipeline. Takes
// the registered CSR write and retire pulse from MEM/WB, serves a
// combinational read port to EX, keeps the 64-bit cycle/instret counters and
// updates mstatus/mepc/mcause/mtval on trap entry and mret.
//
// Ports:
//   clk_in, reset_in                  clock, synchronous active-high reset
//   csr_we_in/csr_waddr_in/csr_wdata_in  CSR write from MEM/WB
//   instret_incr_in                   retire pulse
//   csr_raddr_in                      read address from EX
//   csr_rdata_out, csr_illegal_out    combinational read data / unimplemented flag
//   trap_valid_in, trap_pc_in, trap_cause_in, trap_val_in  trap entry
//   mret_in                           mret retiring
//   mtvec_out, mepc_out, global_ie_out  registered state outputs
`timescale 1ns/1ps
module csr_file #(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          ADDR_W      = 12,
    parameter logic [DATA_W-1:0]    MTVEC_RESET = 32'h0000_0000,
    parameter logic [DATA_W-1:0]    MISA_VALUE  = 32'h4000_0100
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                csr_we_in,
    input  logic [ADDR_W-1:0]   csr_waddr_in,
    input  logic [DATA_W-1:0]   csr_wdata_in,
    input  logic                instret_incr_in,
    input  logic [ADDR_W-1:0]   csr_raddr_in,
    output logic [DATA_W-1:0]   csr_rdata_out,
    output logic                csr_illegal_out,
    input  logic                trap_valid_in,
    input  logic [DATA_W-1:0]   trap_pc_in,
    input  logic [DATA_W-1:0]   trap_cause_in,
    input  logic [DATA_W-1:0]   trap_val_in,
    input  logic                mret_in,
    output logic [DATA_W-1:0]   mtvec_out,
    output logic [DATA_W-1:0]   mepc_out,
    output logic                global_ie_out
);

    localparam int unsigned CNT_W = 2 * DATA_W;

    localparam logic [ADDR_W-1:0] A_MSTATUS   = 12'h300;
    localparam logic [ADDR_W-1:0] A_MISA      = 12'h301;
    localparam logic [ADDR_W-1:0] A_MIE       = 12'h304;
    localparam logic [ADDR_W-1:0] A_MTVEC     = 12'h305;
    localparam logic [ADDR_W-1:0] A_MSCRATCH  = 12'h340;
    localparam logic [ADDR_W-1:0] A_MEPC      = 12'h341;
    localparam logic [ADDR_W-1:0] A_MCAUSE    = 12'h342;
    localparam logic [ADDR_W-1:0] A_MTVAL     = 12'h343;
    localparam logic [ADDR_W-1:0] A_MIP       = 12'h344;
    localparam logic [ADDR_W-1:0] A_MCYCLE    = 12'hB00;
    localparam logic [ADDR_W-1:0] A_MCYCLEH   = 12'hB80;
    localparam logic [ADDR_W-1:0] A_MINSTRET  = 12'hB02;
    localparam logic [ADDR_W-1:0] A_MINSTRETH = 12'hB82;
    localparam logic [ADDR_W-1:0] A_CYCLE     = 12'hC00;
    localparam logic [ADDR_W-1:0] A_CYCLEH    = 12'hC80;
    localparam logic [ADDR_W-1:0] A_INSTRET   = 12'hC02;
    localparam logic [ADDR_W-1:0] A_INSTRETH  = 12'hC82;

    // mtvec and mepc are word aligned: bits [1:0] always cleared
    localparam logic [DATA_W-1:0] LOW2_CLR = ~DATA_W'(3);

    logic                r_mstatus_mie;
    logic                r_mstatus_mpie;
    logic [DATA_W-1:0]   r_mie;
    logic [DATA_W-1:0]   r_mtvec;
    logic [DATA_W-1:0]   r_mscratch;
    logic [DATA_W-1:0]   r_mepc;
    logic [DATA_W-1:0]   r_mcause;
    logic [DATA_W-1:0]   r_mtval;
    logic [CNT_W-1:0]    r_mcycle;
    logic [CNT_W-1:0]    r_minstret;

    logic [DATA_W-1:0]   w_mstatus;
    logic [DATA_W-1:0]   w_wval;
    logic                w_writable;
    logic                w_fwd;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_illegal;
    logic [CNT_W-1:0]    w_mcycle_inc;
    logic [CNT_W-1:0]    w_minstret_inc;
    logic [CNT_W-1:0]    w_mcycle_nxt;
    logic [CNT_W-1:0]    w_minstret_nxt;
    logic                w_wr_mstatus;

    // mstatus image: MPP hardwired to M-mode, only MIE/MPIE stored
    function automatic logic [DATA_W-1:0] f_mstatus(input logic mie, input logic mpie);
        logic [DATA_W-1:0] v;
        v        = '0;
        v[12:11] = 2'b11;
        v[7]     = mpie;
        v[3]     = mie;
        return v;
    endfunction

    assign w_mstatus    = f_mstatus(r_mstatus_mie, r_mstatus_mpie);
    assign w_wr_mstatus = csr_we_in && (csr_waddr_in == A_MSTATUS);

    // Masked write value (what the register will hold) and writability
    always_comb begin
        w_wval     = csr_wdata_in;
        w_writable = 1'b0;
        case (csr_waddr_in)
            A_MSTATUS: begin
                w_wval     = f_mstatus(csr_wdata_in[3], csr_wdata_in[7]);
                w_writable = 1'b1;
            end
            A_MTVEC, A_MEPC: begin
                w_wval     = csr_wdata_in & LOW2_CLR;
                w_writable = 1'b1;
            end
            A_MIE, A_MSCRATCH, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: begin
                w_writable = 1'b1;
            end
            default: begin
                w_writable = 1'b0;
            end
        endcase
    end

    assign w_fwd = csr_we_in && w_writable && (csr_waddr_in == csr_raddr_in);

    always_comb begin
        w_rdata   = '0;
        w_illegal = 1'b0;
        case (csr_raddr_in)
            A_MSTATUS:               w_rdata = w_mstatus;
            A_MISA:                  w_rdata = MISA_VALUE;
            A_MIE:                   w_rdata = r_mie;
            A_MTVEC:                 w_rdata = r_mtvec;
            A_MSCRATCH:              w_rdata = r_mscratch;
            A_MEPC:                  w_rdata = r_mepc;
            A_MCAUSE:                w_rdata = r_mcause;
            A_MTVAL:                 w_rdata = r_mtval;
            A_MIP:                   w_rdata = '0;
            A_MCYCLE, A_CYCLE:       w_rdata = r_mcycle[DATA_W-1:0];
            A_MCYCLEH, A_CYCLEH:     w_rdata = r_mcycle[CNT_W-1:DATA_W];
            A_MINSTRET, A_INSTRET:   w_rdata = r_minstret[DATA_W-1:0];
            A_MINSTRETH, A_INSTRETH: w_rdata = r_minstret[CNT_W-1:DATA_W];
            default:                 w_illegal = 1'b1;
        endcase
        if (w_fwd) begin
            w_rdata = w_wval;
        end
    end

    assign csr_rdata_out   = w_rdata;
    assign csr_illegal_out = w_illegal;

    // Counter next values. Writing the low half replaces it and drops the
    // carry into the high half; writing the high half keeps the low-half
    // increment but overrides whatever carry it produced.
    assign w_mcycle_inc   = r_mcycle + CNT_W'(1);
    assign w_minstret_inc = r_minstret + CNT_W'(instret_incr_in);

    always_comb begin
        w_mcycle_nxt = w_mcycle_inc;
        if (csr_we_in && (csr_waddr_in == A_MCYCLE)) begin
            w_mcycle_nxt = {r_mcycle[CNT_W-1:DATA_W], csr_wdata_in};
        end else if (csr_we_in && (csr_waddr_in == A_MCYCLEH)) begin
            w_mcycle_nxt = {csr_wdata_in, w_mcycle_inc[DATA_W-1:0]};
        end
    end

    always_comb begin
        w_minstret_nxt = w_minstret_inc;
        if (csr_we_in && (csr_waddr_in == A_MINSTRET)) begin
            w_minstret_nxt = {r_minstret[CNT_W-1:DATA_W], csr_wdata_in};
        end else if (csr_we_in && (csr_waddr_in == A_MINSTRETH)) begin
            w_minstret_nxt = {csr_wdata_in, w_minstret_inc[DATA_W-1:0]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_mcycle       <= '0;
            r_minstret     <= '0;
        end else begin
            r_mcycle   <= w_mcycle_nxt;
            r_minstret <= w_minstret_nxt;

            // trap > mret > CSR write for the trap-state registers
            if (trap_valid_in) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret_in) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wr_mstatus) begin
                r_mstatus_mie  <= csr_wdata_in[3];
                r_mstatus_mpie <= csr_wdata_in[7];
            end

            if (trap_valid_in) begin
                r_mepc   <= trap_pc_in & LOW2_CLR;
                r_mcause <= trap_cause_in;
                r_mtval  <= trap_val_in;
            end else if (csr_we_in) begin
                if (csr_waddr_in == A_MEPC)   r_mepc   <= csr_wdata_in & LOW2_CLR;
                if (csr_waddr_in == A_MCAUSE) r_mcause <= csr_wdata_in;
                if (csr_waddr_in == A_MTVAL)  r_mtval  <= csr_wdata_in;
            end

            if (csr_we_in && (csr_waddr_in == A_MIE))      r_mie      <= csr_wdata_in;
            if (csr_we_in && (csr_waddr_in == A_MTVEC))    r_mtvec    <= csr_wdata_in & LOW2_CLR;
            if (csr_we_in && (csr_waddr_in == A_MSCRATCH)) r_mscratch <= csr_wdata_in;
        end
    end

    assign mtvec_out     = r_mtvec;
    assign mepc_out      = r_mepc;
    assign global_ie_out = r_mstatus_mie;

endmodule
